push_pop_fifo: RTL

- Parametrised word FIFO joining a push-style producer to a pop-style consumer using the request/done handshake of the IPush/IPop interfaces.
- Generalises the fixed-width data path to DATA_W bits and adds configurable DEPTH, occupancy reporting, full/empty flags and a synchronous flush.
- Sits between the SPI word receiver and the MIL transmit path, and symmetrically on the return path; one instance per direction.

---
 rtl/push_pop_fifo_pkg.sv | 18 +
 rtl/push_pop_fifo_ram.sv | 34 +++
 rtl/push_pop_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/push_pop_fifo_pkg.sv
// Shared defaults and status types for the SPI/MIL word FIFOs.
`ifndef DATAW_TOP
`define DATAW_TOP 15
`endif

package push_pop_fifo_pkg;

  localparam int DEFAULT_DATA_W = `DATAW_TOP + 1;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_USED_W = $clog2(DEFAULT_DEPTH) + 1;

  typedef struct packed {
    logic [DEFAULT_USED_W-1:0] used;
    logic                      full;
    logic                      empty;
  } fifo_status_t;

endpackage

// File: rtl/push_pop_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module push_pop_fifo_ram
  import push_pop_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is left unreset so the tool is free to map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/push_pop_fifo.sv
// Word FIFO bridging an IPush producer to an IPop consumer with count/flags and flush.
module push_pop_fifo
  import push_pop_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int USED_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push_request,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_done,
  input  logic              pop_request,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_done,
  output logic [USED_W-1:0] used,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [USED_W-1:0] used_q, used_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_done_q, pop_done_q;
  logic              push_acc, pop_acc;

  // The done guards limit each port to one transfer per two cycles, so a
  // request held high across its done pulse is never accepted twice.
  assign push_acc = push_request && !push_done_q && !full_q  && !clear;
  assign pop_acc  = pop_request  && !pop_done_q  && !empty_q && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      used_d = used_q + {{(USED_W-1){1'b0}}, push_acc}
                      - {{(USED_W-1){1'b0}}, pop_acc};
    end
    full_d  = (used_d == USED_W'(DEPTH));
    empty_d = (used_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      push_done_q <= 1'b0;
      pop_done_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      push_done_q <= push_acc;
      pop_done_q  <= pop_acc;
    end
  end

  push_pop_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data),
    .re_i    (pop_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (pop_data)
  );

  assign push_done = push_done_q;
  assign pop_done  = pop_done_q;
  assign used      = used_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule
